// File: rtl/serial_pattern_gen.sv
`timescale 1ns/1ps
// serial_pattern_gen
// Transmit side of the serial bit-stream interface. The block accepts a parallel
// pattern through a valid/ready handshake and shifts it out MSB-first, one bit
// per clock. The pattern is sent reps+1 times, then done pulses for one cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   start request; accepted when in_valid && in_ready
//   in_ready  out  high only in IDLE
//   pattern   in   WIDTH bits to send, sampled at the handshake
//   len       in   bits per repetition; 0 or > WIDTH means WIDTH
//   reps      in   extra repetitions (pattern is sent reps+1 times)
//   abort     in   synchronous cancel, returns to IDLE without a done pulse
//   x         out  serial data (registered)
//   x_valid   out  high while x carries a pattern bit (registered)
//   busy      out  high in SEND
//   done      out  one-cycle completion pulse (registered)
//
// state  | meaning
// S_IDLE | waiting for a handshake, in_ready=1
// S_SEND | shifting pattern bits out, one per clock
// S_DONE | single-cycle done pulse, then back to IDLE
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] pat_q,   pat_n;
    logic [LEN_W-1:0] len_q,   len_n;
    logic [REP_W-1:0] rep_q,   rep_n;
    logic [LEN_W-1:0] idx_q,   idx_n;
    logic             x_q,     x_n;
    logic             xv_q,    xv_n;
    logic             done_q,  done_n;
    logic [LEN_W-1:0] len_eff;

    // Bit select through a shift keeps the index width independent of WIDTH.
    function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    always_comb begin
        len_eff = len;
        if (len == '0 || int'(len) > WIDTH) begin
            len_eff = LEN_W'(WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pat_q   <= pat_n;
            len_q   <= len_n;
            rep_q   <= rep_n;
            idx_q   <= idx_n;
            x_q     <= x_n;
            xv_q    <= xv_n;
            done_q  <= done_n;
        end
    end

    // Output registers are loaded with the value for the next cycle, so the
    // first bit is already on x in the cycle right after the handshake.
    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        len_n   = len_q;
        rep_n   = rep_q;
        idx_n   = idx_q;
        x_n     = 1'b0;
        xv_n    = 1'b0;
        done_n  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!abort && in_valid) begin
                    pat_n   = pattern;
                    len_n   = len_eff;
                    rep_n   = reps;
                    idx_n   = len_eff - LEN_W'(1);
                    x_n     = bit_at(pattern, len_eff - LEN_W'(1));
                    xv_n    = 1'b1;
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (idx_q == '0) begin
                    if (rep_q != '0) begin
                        rep_n = rep_q - REP_W'(1);
                        idx_n = len_q - LEN_W'(1);
                        x_n   = bit_at(pat_q, len_q - LEN_W'(1));
                        xv_n  = 1'b1;
                    end else begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end else begin
                    idx_n = idx_q - LEN_W'(1);
                    x_n   = bit_at(pat_q, idx_q - LEN_W'(1));
                    xv_n  = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign x        = x_q;
    assign x_valid  = xv_q;
    assign done     = done_q;
    assign busy     = (state_q == S_SEND);
    assign in_ready = (state_q == S_IDLE);

endmodule
